// File: rtl/rom_ctrl_pkg.sv
// Shared definitions for the ROM burst arbiter.
// Holds the ROM geometry, the burst-length field width, the controller state
// encoding and the address-increment helper.
package rom_ctrl_pkg;

  localparam int ROM_ADDR_W = 12;
  localparam int ROM_DATA_W = 32;
  localparam int LEN_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } rom_ctrl_state_t;

  // Next word address; the ROM address space wraps from 0xFFF to 0x000.
  function automatic logic [ROM_ADDR_W-1:0] next_addr(input logic [ROM_ADDR_W-1:0] addr);
    return addr + 12'd1;
  endfunction

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// Request/response bundle between the clients and the ROM burst arbiter.
//   req_valid/req_ready : per-requester burst handshake (req_ready is one-hot)
//   req_addr/req_len    : per-requester start address and length-minus-one
//   resp_*              : single registered response stream tagged with resp_id
// Modports: slave = arbiter side, master = client side.
interface rom_burst_arbiter_if
  import rom_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][ROM_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][LEN_W-1:0]      req_len;

  logic                               resp_valid;
  logic                               resp_ready;
  logic [ROM_DATA_W-1:0]              resp_data;
  logic [ID_W-1:0]                    resp_id;
  logic                               resp_last;

  modport slave (
    input  req_valid, req_addr, req_len, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_last
  );

  modport master (
    output req_valid, req_addr, req_len, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_last
  );

endinterface

// File: rtl/rom_rr_arbiter.sv
// Combinational round-robin pick among NUM_REQ requesters.
//   req_valid  : request vector
//   last_grant : index granted most recently; search starts just above it
//   grant      : one-hot grant (all zero when nothing is valid)
//   grant_idx  : binary index of the granted requester
module rom_rr_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic            hi_found_s;
  logic            lo_found_s;
  logic [ID_W-1:0] hi_idx_s;
  logic [ID_W-1:0] lo_idx_s;

  // Lowest valid index above last_grant, and lowest valid index at or below it.
  // Scanning downward lets the last hit be the lowest index on each side.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k] && (k > int'(last_grant))) begin
        hi_found_s = 1'b1;
        hi_idx_s   = ID_W'(k);
      end else if (req_valid[k]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = ID_W'(k);
      end else begin
        // idle requester: nothing to record
      end
    end
  end

  // Candidates above last_grant win; otherwise the search wraps to the low side.
  always_comb begin
    grant_idx = hi_found_s ? hi_idx_s : lo_idx_s;
    grant     = (hi_found_s || lo_found_s) ? (NUM_REQ'(1'b1) << grant_idx) : '0;
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one combinational ROM among NUM_REQ burst requesters.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : request/response bundle (slave side)
//   rom_addr   : address to the external ROM (registered)
//   rom_data   : combinational ROM word for rom_addr
//   busy       : high whenever a burst is in progress
// One burst is granted at a time; its words stream out through a registered
// valid/ready stage tagged with the owning requester id.
module rom_burst_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  rom_burst_arbiter_if.slave    bus,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [ROM_DATA_W-1:0] rom_data,
  output logic                  busy
);

  rom_ctrl_state_t       state_r;
  rom_ctrl_state_t       state_nxt_s;
  logic [ID_W-1:0]       last_grant_r;
  logic [ROM_ADDR_W-1:0] cur_addr_r;
  logic [LEN_W-1:0]      remaining_r;
  logic [ID_W-1:0]       owner_r;
  logic                  resp_valid_r;
  logic [ROM_DATA_W-1:0] resp_data_r;
  logic [ID_W-1:0]       resp_id_r;
  logic                  resp_last_r;

  logic [NUM_REQ-1:0]    grant_s;
  logic [ID_W-1:0]       grant_idx_s;
  logic                  accept_s;
  logic                  load_s;
  logic                  drain_done_s;

  rom_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s)
  );

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt_s  = state_r;
    accept_s     = 1'b0;
    load_s       = 1'b0;
    drain_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|grant_s) begin
          accept_s    = 1'b1;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        // Load whenever the output register is empty or being consumed.
        if (!resp_valid_r || bus.resp_ready) begin
          load_s      = 1'b1;
          state_nxt_s = (remaining_r == '0) ? DRAIN : FETCH;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DRAIN: begin
        if (resp_valid_r && bus.resp_ready) begin
          drain_done_s = 1'b1;
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s  = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst counters, grant history and response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= ID_W'(NUM_REQ - 1);
      cur_addr_r   <= '0;
      remaining_r  <= '0;
      owner_r      <= '0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= '0;
      resp_id_r    <= '0;
      resp_last_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        cur_addr_r   <= bus.req_addr[grant_idx_s];
        remaining_r  <= bus.req_len[grant_idx_s];
        owner_r      <= grant_idx_s;
        last_grant_r <= grant_idx_s;
      end else if (load_s) begin
        cur_addr_r   <= next_addr(cur_addr_r);
        remaining_r  <= remaining_r - 4'd1;
        resp_valid_r <= 1'b1;
        resp_data_r  <= rom_data;
        resp_id_r    <= owner_r;
        resp_last_r  <= (remaining_r == '0);
      end else if (drain_done_s) begin
        resp_valid_r <= 1'b0;
        resp_last_r  <= 1'b0;
      end else begin
        resp_valid_r <= resp_valid_r;
      end
    end
  end

  // Grants are only offered in IDLE and never while reset is held.
  assign bus.req_ready  = ((state_r == IDLE) && !reset) ? grant_s : '0;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_last  = resp_last_r;
  assign rom_addr       = cur_addr_r;
  assign busy           = (state_r != IDLE);

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Self-checking bench for rom_burst_arbiter with a behavioural burst model.
`timescale 1ns/1ps
module tb_rom_burst_arbiter;
  import rom_ctrl_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    logic            last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // model state
  bit          pend  [NUM_REQ];
  logic [11:0] paddr [NUM_REQ];
  logic [3:0]  plen  [NUM_REQ];
  int          last_grant_m;
  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int          grant_log[$];
  bit          rdy_pat[$];
  logic [11:0] b_start;
  int          b_len;
  int          b_loaded;
  bit          just_granted;

  rom_burst_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  rom_burst_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ROM contents seen by the block (the ROM itself lives outside the DUT).
  function automatic logic [31:0] rom_fn(input logic [11:0] a);
    case (a)
      12'h000: return 32'h195F7B09;
      12'h001: return 32'h32BED367;
      12'h002: return 32'hDC931451;
      12'h003: return 32'h5D354907;
      12'h004: return 32'h8E1C2A36;
      12'h005: return 32'h0B7D4C92;
      12'h006: return 32'h6A58A3FE;
      12'h007: return 32'h572C7F81;
      12'hFFE: return 32'h00000000;
      12'hFFF: return 32'h00000000;
      default: return {a, 8'hA5, ~a};
    endcase
  endfunction

  assign rom_data = rom_fn(rom_addr);

  // Cycle-by-cycle driver plus model comparison.
  // mode 0: only the requests preloaded in pend[]; 1: every requester keeps a
  // len-0 request pending; 2: random requests. Stops after 'target' grants
  // once the last burst has fully drained.
  task automatic run_traffic(input int mode, input int target, input int ready_pct, input int max_cycles);
    int grants = 0;
    int cyc    = 0;
    bit done   = 0;
    int g;
    bit exp_valid;
    logic [NUM_REQ-1:0] exp_rdy;
    beat_t ob;
    while (!done) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && grants < target && mode == 1) begin
          pend[i] = 1'b1; paddr[i] = 12'($urandom_range(0, 4095)); plen[i] = 4'd0;
        end else if (!pend[i] && grants < target && mode == 2 && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1; paddr[i] = 12'($urandom_range(0, 4095)); plen[i] = 4'($urandom_range(0, 15));
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_valid[i] = pend[i];
        bus.req_addr[i]  = paddr[i];
        bus.req_len[i]   = plen[i];
      end
      if (rdy_pat.size() > 0) bus.resp_ready = rdy_pat.pop_front();
      else bus.resp_ready = ($urandom_range(1, 100) <= ready_pct);
      #1;
      // round robin from the requester after the last grant, only when no burst is open
      g = -1;
      if (exp_q.size() == 0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (last_grant_m + k) % NUM_REQ;
          if (g < 0 && pend[c]) g = c;
        end
      end
      exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        failures++; $display("FAIL req_ready cyc=%0d: got %b want %b", cyc, bus.req_ready, exp_rdy);
      end
      checks++;
      if (busy !== (exp_q.size() != 0)) begin
        failures++; $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, exp_q.size() != 0);
      end
      exp_valid = (exp_q.size() != 0) && !just_granted;
      checks++;
      if (bus.resp_valid !== exp_valid) begin
        failures++; $display("FAIL resp_valid cyc=%0d: got %b want %b", cyc, bus.resp_valid, exp_valid);
      end
      if (bus.resp_valid === 1'b1 && exp_q.size() > 0) begin
        checks++;
        if (bus.resp_data !== exp_q[0].data || bus.resp_id !== exp_q[0].id || bus.resp_last !== exp_q[0].last) begin
          failures++;
          $display("FAIL resp_word cyc=%0d: got %h/%0d/%b want %h/%0d/%b", cyc, bus.resp_data, bus.resp_id,
                   bus.resp_last, exp_q[0].data, exp_q[0].id, exp_q[0].last);
        end
      end
      if (exp_q.size() > 0 && b_loaded <= b_len) begin
        checks++;
        if (rom_addr !== b_start + 12'(b_loaded)) begin
          failures++; $display("FAIL rom_addr cyc=%0d: got %h want %h", cyc, rom_addr, b_start + 12'(b_loaded));
        end
        if (!exp_valid || bus.resp_ready) b_loaded++;
      end
      done = (grants >= target) && (exp_q.size() == 0) && (g < 0);
      if (bus.resp_valid === 1'b1 && bus.resp_ready && exp_q.size() > 0) begin
        ob = '{data: bus.resp_data, id: bus.resp_id, last: bus.resp_last};
        obs_q.push_back(ob);
        void'(exp_q.pop_front());
      end
      just_granted = 1'b0;
      if (g >= 0) begin
        for (int i = 0; i <= int'(plen[g]); i++)
          exp_q.push_back('{data: rom_fn(paddr[g] + 12'(i)), id: ID_W'(g), last: (i == int'(plen[g]))});
        last_grant_m = g; pend[g] = 1'b0; grant_log.push_back(g); grants++;
        just_granted = 1'b1; b_start = paddr[g]; b_len = int'(plen[g]); b_loaded = 0;
        if (grants >= target) for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
      end
      cyc++;
      if (!done && cyc >= max_cycles) begin
        checks++; failures++; $display("FAIL timeout: %0d cycles, grants %0d of %0d", cyc, grants, target);
        done = 1'b1;
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic clear_logs();
    obs_q.delete(); grant_log.delete(); rdy_pat.delete();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '1; bus.req_addr = '0; bus.req_len = '0; bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rom_addr !== 12'h000) begin failures++; $display("FAIL rst_rom_addr: got %h want 000", rom_addr); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'h0) begin failures++; $display("FAIL rst_resp_data: got %h want 0", bus.resp_data); end
    checks++; if (bus.resp_id !== 2'd0) begin failures++; $display("FAIL rst_resp_id: got %0d want 0", bus.resp_id); end
    checks++; if (bus.resp_last !== 1'b0) begin failures++; $display("FAIL rst_resp_last: got %b want 0", bus.resp_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
    reset = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL first_priority: got %b want 0001", bus.req_ready); end
    bus.req_valid = '0;
    last_grant_m = NUM_REQ - 1; exp_q.delete(); just_granted = 1'b0;
  endtask

  task automatic test_round_robin();
    int want [5] = '{0, 1, 2, 3, 0};
    clear_logs();
    run_traffic(1, 5, 100, 200);
    checks++;
    if (grant_log.size() != 5) begin
      failures++; $display("FAIL rr_count: got %0d want 5", grant_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_log[i] != want[i]) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, grant_log[i], want[i]); end
      end
    end
  endtask

  task automatic test_single();
    clear_logs();
    pend[0] = 1'b1; paddr[0] = 12'h000; plen[0] = 4'd0;
    run_traffic(0, 1, 100, 50);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 32'h195F7B09 || obs_q[0].id !== 2'd0 || obs_q[0].last !== 1'b1) begin
      failures++; $display("FAIL single_word: got %0d beats first %h want 1 beat 195f7b09", obs_q.size(), obs_q.size() > 0 ? obs_q[0].data : 32'h0);
    end
  endtask

  task automatic test_burst8();
    logic [31:0] want [8] = '{32'h195F7B09, 32'h32BED367, 32'hDC931451, 32'h5D354907,
                               32'h8E1C2A36, 32'h0B7D4C92, 32'h6A58A3FE, 32'h572C7F81};
    clear_logs();
    pend[2] = 1'b1; paddr[2] = 12'h000; plen[2] = 4'd7;
    run_traffic(0, 1, 100, 50);
    checks++;
    if (obs_q.size() != 8) begin
      failures++; $display("FAIL burst8_count: got %0d want 8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_q[i].data !== want[i] || obs_q[i].id !== 2'd2 || obs_q[i].last !== (i == 7)) begin
          failures++; $display("FAIL burst8_beat[%0d]: got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last, want[i], i == 7);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [4] = '{32'h0, 32'h0, 32'h195F7B09, 32'h32BED367};
    clear_logs();
    pend[3] = 1'b1; paddr[3] = 12'hFFE; plen[3] = 4'd3;
    run_traffic(0, 1, 100, 50);
    checks++;
    if (obs_q.size() != 4) begin
      failures++; $display("FAIL wrap_count: got %0d want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i].data !== want[i]) begin failures++; $display("FAIL wrap_beat[%0d]: got %h want %h", i, obs_q[i].data, want[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want [3] = '{32'h32BED367, 32'hDC931451, 32'h5D354907};
    clear_logs();
    // grant cycle, first-load cycle, then 1,0,0,1,1 while words are presented
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pend[1] = 1'b1; paddr[1] = 12'h001; plen[1] = 4'd2;
    run_traffic(0, 1, 100, 50);
    checks++;
    if (obs_q.size() != 3) begin
      failures++; $display("FAIL bp_count: got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i].data !== want[i] || obs_q[i].id !== 2'd1) begin
          failures++; $display("FAIL bp_beat[%0d]: got %h want %h", i, obs_q[i].data, want[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    clear_logs();
    run_traffic(2, 24, 60, 3000);
    checks++;
    if (grant_log.size() != 24) begin failures++; $display("FAIL rand_grants: got %0d want 24", grant_log.size()); end
  endtask

  task automatic test_reset_mid_burst();
    int seen = 0;
    bit hit  = 1'b0;
    clear_logs();
    @(posedge clk); #1;
    bus.req_valid = '0; bus.req_valid[1] = 1'b1; bus.req_addr[1] = 12'h000; bus.req_len[1] = 4'd7;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(posedge clk); #1;
      bus.req_valid = '0;
      #1;
      if (bus.resp_valid === 1'b1) begin
        checks++;
        if (bus.resp_data !== rom_fn(12'(seen)) || bus.resp_last !== 1'b0) begin
          failures++; $display("FAIL abort_beat[%0d]: got %h/%b want %h/0", seen, bus.resp_data, bus.resp_last, rom_fn(12'(seen)));
        end
        seen++;
      end
      hit = (seen == 3);
    end
    if (!hit) begin checks++; failures++; $display("FAIL abort_timeout: got %0d beats want 3", seen); end
    bus.req_valid[2] = 1'b1;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL abort_resp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (rom_addr !== 12'h000) begin failures++; $display("FAIL abort_rom_addr: got %h want 000", rom_addr); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL abort_req_ready: got %b want 0000", bus.req_ready); end
    checks++; if (bus.resp_last !== 1'b0) begin failures++; $display("FAIL abort_resp_last: got %b want 0", bus.resp_last); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    reset = 1'b0;
    last_grant_m = NUM_REQ - 1; exp_q.delete(); just_granted = 1'b0;
    pend[0] = 1'b1; paddr[0] = 12'h007; plen[0] = 4'd0;
    run_traffic(0, 1, 100, 50);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 32'h572C7F81 || obs_q[0].last !== 1'b1) begin
      failures++; $display("FAIL after_reset_word: got %0d beats first %h want 1 beat 572c7f81", obs_q.size(), obs_q.size() > 0 ? obs_q[0].data : 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_burst8();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
